// File: rtl/cube_fall_ctrl.sv
// rtl/cube_fall_ctrl.sv - FallingCubes game-state sequencer driven by the VGA frame tick
module cube_fall_ctrl #(
  parameter int N_CUBES      = 4,
  parameter int CUBE_SIZE    = 16,
  parameter int H_DISP       = 640,
  parameter int V_DISP       = 480,
  parameter int FALL_STEP    = 2,
  parameter int SPAWN_FRAMES = 30,
  parameter int MAX_MISS     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p_tick,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  start,
  output logic [10*N_CUBES-1:0] cube_x,
  output logic [10*N_CUBES-1:0] cube_y,
  output logic [N_CUBES-1:0]    cube_act,
  output logic [3:0]            miss_cnt,
  output logic                  game_over,
  output logic                  busy
);

  localparam int IW = (N_CUBES > 1) ? $clog2(N_CUBES) : 1;
  localparam int SW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
  localparam logic [9:0]  X_MAX  = 10'(H_DISP - CUBE_SIZE);
  localparam logic [10:0] Y_LAST = 11'(V_DISP - CUBE_SIZE);

  typedef enum logic [2:0] {IDLE, RUN, UPDATE, SPAWN, GAME_OVER} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     idx;
  logic [SW-1:0]     spawn_cnt;
  logic [9:0]        lfsr;
  logic [9:0]        x_r [N_CUBES];
  logic [9:0]        y_r [N_CUBES];
  logic [N_CUBES-1:0] act_r;

  logic              frame_tick;
  logic              free_found;
  logic [IW-1:0]     free_idx;
  logic [10:0]       y_step;
  logic              retire;
  logic [9:0]        spawn_x;

  // Start of vertical blank: first pixel of the first row below the visible area
  assign frame_tick = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'(V_DISP));

  // Slot currently walked in UPDATE; an 11-bit sum keeps the bottom check from wrapping
  assign y_step  = {1'b0, y_r[idx]} + 11'(FALL_STEP);
  assign retire  = y_step > Y_LAST;
  assign spawn_x = (lfsr > X_MAX) ? (lfsr - X_MAX) : lfsr;

  // Lowest-index inactive slot for the next spawn
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_CUBES - 1; i >= 0; i--) begin
      if (!act_r[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = RUN;
      RUN:       if (frame_tick) state_nx = UPDATE;
      UPDATE:    if (idx == IW'(N_CUBES - 1)) state_nx = SPAWN;
      SPAWN:     state_nx = (miss_cnt >= 4'(MAX_MISS)) ? GAME_OVER : RUN;
      GAME_OVER: if (start) state_nx = RUN;
      default:   state_nx = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy      = (state == UPDATE) || (state == SPAWN);
    game_over = (state == GAME_OVER);
  end

  // Game datapath: slot walk, spawning, miss counting and the free-running LFSR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      spawn_cnt <= '0;
      miss_cnt  <= 4'd0;
      lfsr      <= 10'h001;
      act_r     <= '0;
      for (int i = 0; i < N_CUBES; i++) begin
        x_r[i] <= 10'd0;
        y_r[i] <= 10'd0;
      end
    end else begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      case (state)
        IDLE, GAME_OVER: begin
          if (start) begin
            spawn_cnt <= '0;
            miss_cnt  <= 4'd0;
            act_r     <= '0;
            for (int i = 0; i < N_CUBES; i++) begin
              x_r[i] <= 10'd0;
              y_r[i] <= 10'd0;
            end
          end
        end
        RUN: begin
          if (frame_tick) idx <= '0;
        end
        UPDATE: begin
          if (act_r[idx]) begin
            if (retire) begin
              act_r[idx] <= 1'b0;
              miss_cnt   <= (miss_cnt >= 4'(MAX_MISS)) ? 4'(MAX_MISS) : miss_cnt + 4'd1;
            end else begin
              y_r[idx] <= y_step[9:0];
            end
          end
          idx <= idx + IW'(1);
        end
        SPAWN: begin
          if (spawn_cnt == SW'(SPAWN_FRAMES - 1)) begin
            spawn_cnt <= '0;
            if (free_found) begin
              act_r[free_idx] <= 1'b1;
              x_r[free_idx]   <= spawn_x;
              y_r[free_idx]   <= 10'd0;
            end
          end else begin
            spawn_cnt <= spawn_cnt + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Flatten slot registers onto the packed output buses
  always_comb begin
    cube_x   = '0;
    cube_y   = '0;
    cube_act = act_r;
    for (int i = 0; i < N_CUBES; i++) begin
      cube_x[10*i +: 10] = x_r[i];
      cube_y[10*i +: 10] = y_r[i];
    end
  end

endmodule

// File: tb/tb_cube_fall_ctrl.sv
// tb/tb_cube_fall_ctrl.sv - directed self-checking bench for cube_fall_ctrl
module tb_cube_fall_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p_tick = 1'b0;
  logic [9:0]  pixel_x = 10'd0;
  logic [9:0]  pixel_y = 10'd0;
  logic        start = 1'b0;
  logic [39:0] cube_x;
  logic [39:0] cube_y;
  logic [3:0]  cube_act;
  logic [3:0]  miss_cnt;
  logic        game_over;
  logic        busy;

  int total = 0;
  int bad = 0;

  logic [9:0] m_lfsr;
  int          nb;
  logic [9:0]  sp;
  logic [9:0]  exp_x;

  cube_fall_ctrl dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .start(start), .cube_x(cube_x), .cube_y(cube_y), .cube_act(cube_act),
    .miss_cnt(miss_cnt), .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference x^10+x^7+1 Fibonacci sequence, free running like the game's generator
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 10'h001;
    else        m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  function automatic logic [9:0] fold(input logic [9:0] v);
    return (v > 10'd624) ? v - 10'd624 : v;
  endfunction

  // One frame tick, then observe 8 cycles: count busy cycles and keep the LFSR value seen in SPAWN
  task automatic do_frame(output int nbusy, output logic [9:0] sp_lfsr);
    nbusy = 0;
    sp_lfsr = 10'd0;
    @(negedge clk);
    p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd480;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin p_tick = 1'b0; pixel_y = 10'd0; end
      if (busy) begin
        nbusy++;
        sp_lfsr = m_lfsr;
      end
    end
  endtask

  task automatic run_frames(input int n);
    int          b;
    logic [9:0]  s;
    for (int f = 0; f < n; f++) begin
      do_frame(b, s);
      total++;
      if (b !== 5) begin bad++; $display("FAIL run_busy frame %0d: got %0d want 5", f, b); end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cube_x, cube_y, cube_act, miss_cnt, game_over, busy} !== '0) begin
      bad++; $display("FAIL reset_state: x=%h y=%h act=%b miss=%0d go=%b busy=%b want all 0",
                      cube_x, cube_y, cube_act, miss_cnt, game_over, busy);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle();
    for (int k = 0; k < 3; k++) begin
      do_frame(nb, sp);
      total++;
      if (nb !== 0) begin bad++; $display("FAIL idle_busy: got %0d want 0", nb); end
    end
    total++;
    if (cube_act !== 4'b0000) begin bad++; $display("FAIL idle_act: got %b want 0000", cube_act); end
  endtask

  task automatic test_first_spawn();
    pulse_start();
    run_frames(29);
    total++;
    if (cube_act !== 4'b0000) begin bad++; $display("FAIL pre_spawn_act: got %b want 0000", cube_act); end
    do_frame(nb, sp);
    exp_x = fold(sp);
    total++;
    if (nb !== 5) begin bad++; $display("FAIL spawn_busy: got %0d want 5", nb); end
    total++;
    if (cube_act !== 4'b0001) begin bad++; $display("FAIL spawn_act: got %b want 0001", cube_act); end
    total++;
    if (cube_y[9:0] !== 10'd0) begin bad++; $display("FAIL spawn_y: got %0d want 0", cube_y[9:0]); end
    total++;
    if (cube_x[9:0] !== exp_x) begin bad++; $display("FAIL spawn_x: got %0d want %0d", cube_x[9:0], exp_x); end
    total++;
    if (exp_x < 10'd1 || exp_x > 10'd624) begin bad++; $display("FAIL spawn_x_range: got %0d want 1..624", exp_x); end
  endtask

  task automatic test_fall();
    run_frames(10);
    total++;
    if (cube_y[9:0] !== 10'd20) begin bad++; $display("FAIL fall_y: got %0d want 20", cube_y[9:0]); end
    // near-miss timing points must not start a frame update
    nb = 0;
    @(negedge clk); p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd479;
    @(negedge clk); pixel_x = 10'd1; pixel_y = 10'd480;
    @(negedge clk); p_tick = 1'b0; pixel_x = 10'd0; pixel_y = 10'd480;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    pixel_y = 10'd0;
    total++;
    if (nb !== 0) begin bad++; $display("FAIL no_tick_busy: got %0d want 0", nb); end
    total++;
    if (cube_y[9:0] !== 10'd20) begin bad++; $display("FAIL no_tick_y: got %0d want 20", cube_y[9:0]); end
  endtask

  task automatic test_full_spawn();
    // frames 41..150: slots spawn at 60, 90, 120; frame 150 finds no free slot
    run_frames(110);
    total++;
    if (cube_act !== 4'b1111) begin bad++; $display("FAIL full_act: got %b want 1111", cube_act); end
    total++;
    if (cube_y !== {10'd60, 10'd120, 10'd180, 10'd240}) begin
      bad++; $display("FAIL full_y: got %h want %h", cube_y, {10'd60, 10'd120, 10'd180, 10'd240});
    end
  endtask

  task automatic test_miss();
    run_frames(112);
    total++;
    if (cube_y[9:0] !== 10'd464 || cube_act[0] !== 1'b1 || miss_cnt !== 4'd0) begin
      bad++; $display("FAIL bottom_edge: y=%0d act=%b miss=%0d want 464 1 0", cube_y[9:0], cube_act[0], miss_cnt);
    end
    run_frames(1);
    total++;
    if (cube_act[0] !== 1'b0 || cube_y[9:0] !== 10'd464 || miss_cnt !== 4'd1) begin
      bad++; $display("FAIL retire: act=%b y=%0d miss=%0d want 0 464 1", cube_act[0], cube_y[9:0], miss_cnt);
    end
    // frame 270: spawn counter was cleared by the skipped spawns, so slot0 refills here
    run_frames(6);
    total++;
    if (cube_act !== 4'b1110) begin bad++; $display("FAIL pre_refill_act: got %b want 1110", cube_act); end
    do_frame(nb, sp);
    exp_x = fold(sp);
    total++;
    if (cube_act !== 4'b1111 || cube_y[9:0] !== 10'd0 || cube_x[9:0] !== exp_x) begin
      bad++; $display("FAIL refill: act=%b y=%0d x=%0d want 1111 0 %0d", cube_act, cube_y[9:0], cube_x[9:0], exp_x);
    end
  endtask

  task automatic test_game_over();
    logic [39:0] y_snap;
    run_frames(53);
    total++;
    if (game_over !== 1'b1 || miss_cnt !== 4'd3) begin
      bad++; $display("FAIL game_over: go=%b miss=%0d want 1 3", game_over, miss_cnt);
    end
    total++;
    if (cube_act !== 4'b1011) begin bad++; $display("FAIL go_act: got %b want 1011", cube_act); end
    total++;
    if (cube_y[39:30] !== 10'd406 || cube_y[9:0] !== 10'd106 || cube_y[19:10] !== 10'd46) begin
      bad++; $display("FAIL go_y: got %h want y3=406 y1=46 y0=106", cube_y);
    end
    y_snap = {10'd406, cube_y[29:20], 10'd46, 10'd106};
    do_frame(nb, sp);
    total++;
    if (nb !== 0 || cube_y !== y_snap || cube_act !== 4'b1011) begin
      bad++; $display("FAIL frozen: busy=%0d y=%h act=%b want 0 %h 1011", nb, cube_y, cube_act, y_snap);
    end
    pulse_start();
    total++;
    if (game_over !== 1'b0 || miss_cnt !== 4'd0 || cube_act !== 4'b0000 || cube_x !== '0 || cube_y !== '0) begin
      bad++; $display("FAIL restart_clear: go=%b miss=%0d act=%b x=%h y=%h want all 0",
                      game_over, miss_cnt, cube_act, cube_x, cube_y);
    end
    run_frames(1);
  endtask

  task automatic test_reset_mid();
    // after restart: frame 1 done; spawn at frame 30, then 5 more frames
    run_frames(34);
    total++;
    if (cube_act !== 4'b0001 || cube_y[9:0] !== 10'd10) begin
      bad++; $display("FAIL pre_reset: act=%b y=%0d want 0001 10", cube_act, cube_y[9:0]);
    end
    @(negedge clk); p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd480;
    @(negedge clk); p_tick = 1'b0; pixel_y = 10'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({cube_x, cube_y, cube_act, miss_cnt, game_over, busy} !== '0) begin
      bad++; $display("FAIL mid_reset: x=%h y=%h act=%b miss=%0d go=%b busy=%b want all 0",
                      cube_x, cube_y, cube_act, miss_cnt, game_over, busy);
    end
    @(negedge clk); reset = 1'b1;
    do_frame(nb, sp);
    total++;
    if (nb !== 0 || cube_act !== 4'b0000) begin
      bad++; $display("FAIL post_reset_idle: busy=%0d act=%b want 0 0000", nb, cube_act);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_first_spawn();
    test_fall();
    test_full_spawn();
    test_miss();
    test_game_over();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
